// File: rtl/alu_rs.sv
// Reservation station for the single ALU: holds dispatched ALU/branch/jump ops,
// snoops ALU/LSB broadcasts for operand tags, and issues one ready entry per cycle.
module alu_rs #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              issue_valid,
  input  logic [5:0]        issue_op,
  input  logic [31:0]       issue_inst,
  input  logic [31:0]       issue_pc,
  input  logic [31:0]       issue_imm,
  input  logic [31:0]       issue_vj,
  input  logic [ROB_W-1:0]  issue_qj,
  input  logic              issue_qj_busy,
  input  logic [31:0]       issue_vk,
  input  logic [ROB_W-1:0]  issue_qk,
  input  logic              issue_qk_busy,
  input  logic [ROB_W-1:0]  issue_entry,
  output logic              rs_full,
  input  logic              alu_bc_valid,
  input  logic [31:0]       alu_bc_result,
  input  logic [ROB_W-1:0]  alu_bc_entry,
  input  logic              lsb_bc_valid,
  input  logic [31:0]       lsb_bc_result,
  input  logic [ROB_W-1:0]  lsb_bc_entry,
  output logic              new_calculate,
  output logic [5:0]        alu_op,
  output logic [31:0]       alu_inst,
  output logic [31:0]       alu_vj,
  output logic [31:0]       alu_vk,
  output logic [31:0]       alu_pc,
  output logic [31:0]       alu_imm,
  output logic [ROB_W-1:0]  alu_entry
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy, qj_busy, qk_busy;
  logic [5:0]         op_q    [RS_SIZE];
  logic [31:0]        inst_q  [RS_SIZE];
  logic [31:0]        pc_q    [RS_SIZE];
  logic [31:0]        imm_q   [RS_SIZE];
  logic [31:0]        vj_q    [RS_SIZE];
  logic [31:0]        vk_q    [RS_SIZE];
  logic [ROB_W-1:0]   qj_q    [RS_SIZE];
  logic [ROB_W-1:0]   qk_q    [RS_SIZE];
  logic [ROB_W-1:0]   entry_q [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic               sel_valid, free_valid;
  logic [31:0]        new_vj, new_vk;
  logic               new_qj_busy, new_qk_busy;

  assign ready   = busy & ~qj_busy & ~qk_busy;
  assign rs_full = &busy;

  // Lowest-index ready entry and lowest-index free entry, both from pre-edge state.
  always_comb begin
    sel_idx    = '0;
    sel_valid  = 1'b0;
    free_idx   = '0;
    free_valid = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        sel_valid = 1'b1;
      end
      if (!busy[i]) begin
        free_idx   = IDX_W'(i);
        free_valid = 1'b1;
      end
    end
  end

  // Same-cycle bypass of broadcasts into the incoming instruction; ALU wins over LSB.
  always_comb begin
    new_vj      = issue_vj;
    new_qj_busy = issue_qj_busy;
    new_vk      = issue_vk;
    new_qk_busy = issue_qk_busy;
    if (issue_qj_busy) begin
      if (alu_bc_valid && alu_bc_entry == issue_qj) begin
        new_vj      = alu_bc_result;
        new_qj_busy = 1'b0;
      end else if (lsb_bc_valid && lsb_bc_entry == issue_qj) begin
        new_vj      = lsb_bc_result;
        new_qj_busy = 1'b0;
      end
    end
    if (issue_qk_busy) begin
      if (alu_bc_valid && alu_bc_entry == issue_qk) begin
        new_vk      = alu_bc_result;
        new_qk_busy = 1'b0;
      end else if (lsb_bc_valid && lsb_bc_entry == issue_qk) begin
        new_vk      = lsb_bc_result;
        new_qk_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy          <= '0;
      qj_busy       <= '0;
      qk_busy       <= '0;
      new_calculate <= 1'b0;
      alu_op        <= '0;
      alu_inst      <= '0;
      alu_vj        <= '0;
      alu_vk        <= '0;
      alu_pc        <= '0;
      alu_imm       <= '0;
      alu_entry     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]    <= '0;
        inst_q[i]  <= '0;
        pc_q[i]    <= '0;
        imm_q[i]   <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        entry_q[i] <= '0;
      end
    end else if (!rdy_in) begin
      new_calculate <= 1'b0;
    end else if (clear_in) begin
      busy          <= '0;
      new_calculate <= 1'b0;
    end else begin
      // Wakeup of waiting operands from either broadcast bus.
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && qj_busy[i]) begin
          if (alu_bc_valid && alu_bc_entry == qj_q[i]) begin
            vj_q[i]    <= alu_bc_result;
            qj_busy[i] <= 1'b0;
          end else if (lsb_bc_valid && lsb_bc_entry == qj_q[i]) begin
            vj_q[i]    <= lsb_bc_result;
            qj_busy[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_busy[i]) begin
          if (alu_bc_valid && alu_bc_entry == qk_q[i]) begin
            vk_q[i]    <= alu_bc_result;
            qk_busy[i] <= 1'b0;
          end else if (lsb_bc_valid && lsb_bc_entry == qk_q[i]) begin
            vk_q[i]    <= lsb_bc_result;
            qk_busy[i] <= 1'b0;
          end
        end
      end

      new_calculate <= sel_valid;
      if (sel_valid) begin
        alu_op        <= op_q[sel_idx];
        alu_inst      <= inst_q[sel_idx];
        alu_vj        <= vj_q[sel_idx];
        alu_vk        <= vk_q[sel_idx];
        alu_pc        <= pc_q[sel_idx];
        alu_imm       <= imm_q[sel_idx];
        alu_entry     <= entry_q[sel_idx];
        busy[sel_idx] <= 1'b0;
      end

      // The free slot is never the selected one, so allocation cannot collide with dispatch.
      if (issue_valid && free_valid) begin
        busy[free_idx]    <= 1'b1;
        op_q[free_idx]    <= issue_op;
        inst_q[free_idx]  <= issue_inst;
        pc_q[free_idx]    <= issue_pc;
        imm_q[free_idx]   <= issue_imm;
        vj_q[free_idx]    <= new_vj;
        qj_q[free_idx]    <= issue_qj;
        qj_busy[free_idx] <= new_qj_busy;
        vk_q[free_idx]    <= new_vk;
        qk_q[free_idx]    <= issue_qk;
        qk_busy[free_idx] <= new_qk_busy;
        entry_q[free_idx] <= issue_entry;
      end
    end
  end

endmodule
